// File: rtl/stack_arbiter.sv
// Two-requester round-robin arbiter in front of an external LIFO stack.
// One operation at a time: grant in IDLE, strobe in ISSUE, ack in RESP.
module stack_arbiter #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [1:0]       req,
  input  logic [1:0]       op0,
  input  logic [1:0]       op1,
  input  logic [WIDTH-1:0] wd0,
  input  logic [WIDTH-1:0] wd1,
  output logic [1:0]       ack,
  output logic             err,
  output logic [WIDTH-1:0] rdata,
  output logic             stk_push,
  output logic             stk_pop,
  output logic [WIDTH-1:0] stk_din,
  input  logic [WIDTH-1:0] stk_dout,
  output logic [7:0]       count,
  output logic             full,
  output logic             empty
);

  localparam logic [1:0] OP_PUSH = 2'b00;
  localparam logic [1:0] OP_POP  = 2'b01;
  localparam logic [1:0] OP_TOS  = 2'b10;
  localparam logic [7:0] CAP     = 8'(DEPTH);

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    RESP
  } state_t;

  state_t           state;
  state_t           state_nx;
  logic             gnt;
  logic             gnt_nx;
  logic             last;
  logic [1:0]       op_q;
  logic [WIDTH-1:0] wd_q;
  logic             err_q;
  logic [WIDTH-1:0] rd_q;
  logic             push_ok;
  logic             pop_ok;
  logic             tos_ok;
  logic             op_err;

  assign full  = (count == CAP);
  assign empty = (count == 8'd0);

  // Tie goes to whoever was not served last.
  always_comb begin
    gnt_nx = 1'b0;
    unique case (req)
      2'b01:   gnt_nx = 1'b0;
      2'b10:   gnt_nx = 1'b1;
      2'b11:   gnt_nx = ~last;
      default: gnt_nx = 1'b0;
    endcase
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (|req) state_nx = ISSUE;
      ISSUE:   state_nx = RESP;
      RESP:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    push_ok = 1'b0;
    pop_ok  = 1'b0;
    tos_ok  = 1'b0;
    op_err  = 1'b0;
    unique case (op_q)
      OP_PUSH: begin
        push_ok = ~full;
        op_err  = full;
      end
      OP_POP: begin
        pop_ok = ~empty;
        op_err = empty;
      end
      OP_TOS: begin
        tos_ok = ~empty;
        op_err = empty;
      end
      default: op_err = 1'b1;
    endcase
  end

  always_comb begin
    stk_push = 1'b0;
    stk_pop  = 1'b0;
    stk_din  = '0;
    ack      = 2'b00;
    err      = 1'b0;
    rdata    = '0;
    if (state == ISSUE) begin
      stk_push = push_ok;
      stk_pop  = pop_ok;
      if (push_ok) stk_din = wd_q;
    end
    if (state == RESP) begin
      ack   = gnt ? 2'b10 : 2'b01;
      err   = err_q;
      rdata = rd_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      count <= 8'd0;
      last  <= 1'b1;
      gnt   <= 1'b0;
      op_q  <= 2'b00;
      wd_q  <= '0;
      err_q <= 1'b0;
      rd_q  <= '0;
    end else begin
      state <= state_nx;
      if (state == IDLE && |req) begin
        gnt  <= gnt_nx;
        last <= gnt_nx;
        op_q <= gnt_nx ? op1 : op0;
        wd_q <= gnt_nx ? wd1 : wd0;
      end
      if (state == ISSUE) begin
        err_q <= op_err;
        if (push_ok) begin
          rd_q  <= wd_q;
          count <= count + 8'd1;
        end else if (pop_ok) begin
          rd_q  <= stk_dout;
          count <= count - 8'd1;
        end else if (tos_ok) begin
          rd_q <= stk_dout;
        end else begin
          rd_q <= '0;
        end
      end
    end
  end

endmodule

// File: tb/tb_stack_arbiter.sv
// Scoreboard bench for stack_arbiter with a behavioural stack model
// driving stk_dout from the observed push/pop strobes.
module tb_stack_arbiter;

  localparam int WIDTH = 8;
  localparam int DEPTH = 8;

  logic             clk = 1'b0;
  logic             rst;
  logic [1:0]       req;
  logic [1:0]       op0;
  logic [1:0]       op1;
  logic [WIDTH-1:0] wd0;
  logic [WIDTH-1:0] wd1;
  logic [1:0]       ack;
  logic             err;
  logic [WIDTH-1:0] rdata;
  logic             stk_push;
  logic             stk_pop;
  logic [WIDTH-1:0] stk_din;
  logic [WIDTH-1:0] stk_dout;
  logic [7:0]       count;
  logic             full;
  logic             empty;

  always #5 clk = ~clk;

  stack_arbiter #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .req(req),
    .op0(op0), .op1(op1), .wd0(wd0), .wd1(wd1),
    .ack(ack), .err(err), .rdata(rdata),
    .stk_push(stk_push), .stk_pop(stk_pop),
    .stk_din(stk_din), .stk_dout(stk_dout),
    .count(count), .full(full), .empty(empty)
  );

  logic [7:0] mem [0:255];
  int sp = 0;

  always @(posedge clk) begin
    if (rst) sp <= 0;
    else if (stk_push) begin
      mem[8'(sp)] <= stk_din;
      sp <= sp + 1;
    end else if (stk_pop && sp > 0) sp <= sp - 1;
  end

  assign stk_dout = (sp > 0) ? mem[8'(sp - 1)] : 8'h00;

  typedef struct {
    logic [1:0] ack;
    logic       err;
    logic [7:0] rdata;
    int         cnt;
    logic       push;
    logic       pop;
    logic [7:0] din;
  } exp_t;

  exp_t       sb[$];
  logic [7:0] mstk[$];
  int checks = 0;
  int errors = 0;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic exp_t predict(input int who, input logic [1:0] op,
                                   input logic [7:0] wd);
    exp_t e;
    e.ack = (who == 1) ? 2'b10 : 2'b01;
    e.err = 1'b0;
    e.rdata = 8'h00;
    e.push = 1'b0;
    e.pop = 1'b0;
    e.din = 8'h00;
    case (op)
      2'b00:
        if (mstk.size() < DEPTH) begin
          mstk.push_back(wd);
          e.rdata = wd;
          e.push = 1'b1;
          e.din = wd;
        end else e.err = 1'b1;
      2'b01:
        if (mstk.size() > 0) begin
          e.rdata = mstk.pop_back();
          e.pop = 1'b1;
        end else e.err = 1'b1;
      2'b10:
        if (mstk.size() > 0) e.rdata = mstk[$];
        else e.err = 1'b1;
      default: e.err = 1'b1;
    endcase
    e.cnt = mstk.size();
    return e;
  endfunction

  task automatic apply_reset;
    rst = 1'b1;
    req = 2'b00;
    op0 = 2'b00;
    op1 = 2'b00;
    wd0 = 8'h00;
    wd1 = 8'h00;
    tick;
    tick;
    rst = 1'b0;
    mstk.delete();
    sb.delete();
  endtask

  task automatic do_op(input int who, input logic [1:0] op,
                       input logic [7:0] wd);
    exp_t e;
    exp_t g;
    int   n;
    bit   got;
    e = predict(who, op, wd);
    sb.push_back(e);
    if (who == 0) begin
      req = 2'b01; op0 = op; wd0 = wd;
    end else begin
      req = 2'b10; op1 = op; wd1 = wd;
    end
    tick;
    checks++;
    if (stk_push !== e.push || stk_pop !== e.pop ||
        stk_din !== e.din || ack !== 2'b00) begin
      errors++;
      $display("FAIL issue who=%0d op=%b: push=%b pop=%b din=%h ack=%b, required push=%b pop=%b din=%h ack=00",
               who, op, stk_push, stk_pop, stk_din, ack, e.push, e.pop, e.din);
    end
    got = 0;
    n = 0;
    for (int i = 0; i < 4 && !got; i++) begin
      tick;
      n++;
      if (ack !== 2'b00) got = 1;
    end
    g = sb.pop_front();
    checks++;
    if (!got) begin
      errors++;
      $display("FAIL ack_timeout who=%0d op=%b: no ack, required %b", who, op, g.ack);
    end else if (n != 1 || ack !== g.ack || err !== g.err ||
                 rdata !== g.rdata || count !== 8'(g.cnt) ||
                 stk_push !== 1'b0 || stk_pop !== 1'b0) begin
      errors++;
      $display("FAIL resp who=%0d op=%b: lat=%0d ack=%b err=%b rdata=%h count=%0d, required lat=2 ack=%b err=%b rdata=%h count=%0d",
               who, op, n + 1, ack, err, rdata, count, g.ack, g.err, g.rdata, g.cnt);
    end
    req = 2'b00;
    tick;
    checks++;
    if (ack !== 2'b00 || err !== 1'b0 || rdata !== 8'h00 ||
        count !== 8'(e.cnt) || full !== (e.cnt == DEPTH) ||
        empty !== (e.cnt == 0)) begin
      errors++;
      $display("FAIL idle_after who=%0d: ack=%b err=%b rdata=%h count=%0d full=%b empty=%b, required 00/0/00 count=%0d",
               who, ack, err, rdata, count, full, empty, e.cnt);
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    req = 2'b11;
    op0 = 2'b00;
    op1 = 2'b00;
    wd0 = 8'hE1;
    wd1 = 8'hE2;
    for (int i = 0; i < 3; i++) begin
      tick;
      checks++;
      if (ack !== 2'b00 || stk_push !== 1'b0 || stk_pop !== 1'b0 ||
          count !== 8'd0 || empty !== 1'b1 || full !== 1'b0 ||
          err !== 1'b0 || rdata !== 8'h00 || stk_din !== 8'h00) begin
        errors++;
        $display("FAIL reset_state: ack=%b push=%b pop=%b count=%0d empty=%b full=%b err=%b rdata=%h, required all idle, empty=1",
                 ack, stk_push, stk_pop, count, empty, full, err, rdata);
      end
    end
    apply_reset;
  endtask

  task automatic test_push_pop;
    apply_reset;
    do_op(0, 2'b00, 8'h1F);
    do_op(0, 2'b00, 8'h3C);
    do_op(1, 2'b01, 8'h00);
  endtask

  task automatic test_tos;
    do_op(0, 2'b00, 8'h55);
    do_op(1, 2'b10, 8'h00);
    do_op(0, 2'b11, 8'h00);
    do_op(1, 2'b11, 8'h99);
  endtask

  task automatic test_full_empty;
    apply_reset;
    for (int i = 0; i < DEPTH; i++) do_op(i % 2, 2'b00, 8'(8'h80 + i));
    do_op(0, 2'b00, 8'hAA);
    do_op(1, 2'b10, 8'h00);
    for (int i = 0; i < DEPTH; i++) do_op((i + 1) % 2, 2'b01, 8'h00);
    do_op(0, 2'b01, 8'h00);
    do_op(1, 2'b10, 8'h00);
  endtask

  task automatic test_back_to_back;
    exp_t g;
    int   cyc;
    int   prev;
    int   seen;
    apply_reset;
    for (int i = 0; i < 4; i++)
      sb.push_back(predict(i % 2, 2'b00, (i % 2 == 1) ? 8'h20 : 8'h10));
    req = 2'b11;
    op0 = 2'b00;
    op1 = 2'b00;
    wd0 = 8'h10;
    wd1 = 8'h20;
    prev = -1;
    seen = 0;
    for (cyc = 0; cyc < 30 && seen < 4; cyc++) begin
      tick;
      if (stk_push === 1'b1 && stk_pop === 1'b1) begin
        checks++;
        errors++;
        $display("FAIL b2b_strobes: push and pop both high, required exclusive");
      end
      if (ack !== 2'b00) begin
        g = sb.pop_front();
        seen++;
        checks++;
        if (ack !== g.ack || err !== g.err || rdata !== g.rdata ||
            count !== 8'(g.cnt) || (prev >= 0 && cyc - prev != 3)) begin
          errors++;
          $display("FAIL b2b_ack%0d: ack=%b rdata=%h count=%0d gap=%0d, required ack=%b rdata=%h count=%0d gap=3",
                   seen, ack, rdata, count, cyc - prev, g.ack, g.rdata, g.cnt);
        end
        prev = cyc;
        if (seen == 4) req = 2'b00;
      end
    end
    checks++;
    if (seen != 4) begin
      errors++;
      $display("FAIL b2b_timeout: acks=%0d, required 4", seen);
    end
    tick;
  endtask

  task automatic test_reset_mid;
    apply_reset;
    req = 2'b01;
    op0 = 2'b00;
    wd0 = 8'h77;
    tick;
    checks++;
    if (stk_push !== 1'b1 || stk_din !== 8'h77) begin
      errors++;
      $display("FAIL mid_issue: push=%b din=%h, required 1/77", stk_push, stk_din);
    end
    rst = 1'b1;
    req = 2'b00;
    tick;
    checks++;
    if (ack !== 2'b00 || count !== 8'd0 || err !== 1'b0 ||
        rdata !== 8'h00 || stk_push !== 1'b0 || stk_pop !== 1'b0 ||
        stk_din !== 8'h00 || empty !== 1'b1) begin
      errors++;
      $display("FAIL mid_reset: ack=%b count=%0d err=%b rdata=%h push=%b pop=%b din=%h, required all 0, empty",
               ack, count, err, rdata, stk_push, stk_pop, stk_din);
    end
    tick;
    checks++;
    if (ack !== 2'b00) begin
      errors++;
      $display("FAIL mid_noack: ack=%b, required 00", ack);
    end
    rst = 1'b0;
    mstk.delete();
    sb.delete();
    do_op(1, 2'b00, 8'h42);
    do_op(0, 2'b10, 8'h00);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1);
  end

  initial begin
    test_reset;
    test_push_pop;
    test_tos;
    test_full_empty;
    test_back_to_back;
    test_reset_mid;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
